instr_buffer: RTL and testbench
===============================

# instr_buffer

Instruction buffer between the fetch pipeline and decode. It queues fetched {pc, instr} pairs in a circular FIFO and presents them to ID with a valid/ready handshake. It raises the `stall_full_instr` backpressure that the PC-generation stage uses to hold its PC. The `stall_full_instr` threshold leaves skid room for the fetch stages still in flight. An EX-stage branch redirect flushes the whole buffer.

## Interface
Parameters:
- `DEPTH`, 8: number of entries; power of two, at least 4.
- `SKID`, 2: entries reserved for in-flight fetches; `stall_full_instr` asserts when free entries ≤ `SKID`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `flush`  in  1  branch redirect (EX_BR); discards all entries.
- `in_valid`  in  1  fetched instruction present this cycle.
- `in_pc`  in  32  PC of the fetched instruction.
- `in_instr`  in  32  fetched instruction word.
- `stall_full_instr`  out  1  backpressure to fetch.
- `out_valid`  out  1  head entry valid for ID.
- `out_ready`  in  1  ID accepts the head entry this cycle.
- `out_pc`  out  32  PC of the head entry.
- `out_instr`  out  32  instruction word of the head entry.
- `overflow`  out  1  sticky error flag: a push was dropped because the buffer was full.

## Operation
- State:
  - storage `mem[DEPTH]` of 64 bits each.
  - `wr_ptr` and `rd_ptr`, each log2(DEPTH) bits, wrapping naturally modulo DEPTH.
  - `count`, log2(DEPTH)+1 bits, range 0..DEPTH.
- `push = in_valid & (count != DEPTH)`.
- `pop = out_valid & out_ready`.
- Push: write `mem[wr_ptr] <= {in_pc, in_instr}`, then `wr_ptr++`.
- Pop: `rd_ptr++`.
- Count update:
  - push only: `count+1`.
  - pop only: `count-1`.
  - both, or neither: unchanged.
- Simultaneous push and pop:
  - When full, push is blocked even if pop happens that cycle, so the push condition stays a simple compare.
  - When empty, pop is impossible because `out_valid` is 0. There is no bypass: a pushed entry is visible on the cycle after the push.
- `in_valid=1` while `count==DEPTH`:
  - entry dropped, pointers unchanged.
  - `overflow` set to 1 and held until reset. A correct system never does this.
- Flush:
  - next edge sets `wr_ptr=rd_ptr=count=0`.
  - overrides any push or pop in the same cycle; the in-flight `in_valid` that cycle is discarded.
  - `overflow` is unaffected.
- Outputs:
  - `out_valid = (count != 0)`.
  - `out_pc` and `out_instr` read `mem[rd_ptr]` combinationally (show-ahead).
  - When `out_valid=0`, `out_pc` and `out_instr` are don't-care, but must not be X after reset: `mem` is reset to 0.
- `stall_full_instr = (count >= DEPTH - SKID)`. It is a function of registered `count` only, with no combinational path from any input.

## Timing
- Reset (async, `rstn=0`): immediately `count=0`, pointers 0, `mem` cleared, `out_valid=0`, `stall_full_instr=0`, `overflow=0`. Deassertion is synchronous to the next `clk` edge; the first push is accepted on the first edge with `rstn=1`.
- Reset mid-operation: all contents lost, with the same values as above; no partial state survives.
- Latency: a push on edge N gives `out_valid=1` with that entry in the cycle after edge N, provided it is the head entry.
- `stall_full_instr`:
  - rises in the cycle after the push that makes `count = DEPTH-SKID`.
  - falls in the cycle after the pop that makes `count < DEPTH-SKID`.
  - SKID=2 covers the IF1→IF2 in-flight fetches.
- Flush: `out_valid=0` and `stall_full_instr=0` in the cycle after the flush edge. A push in the next cycle is accepted normally.
- Throughput: one push and one pop per cycle sustained at any occupancy 0<count<DEPTH.

## Test plan
- Reset, then push pc `0x1c000000`/`0x1c000004`/`0x1c000008` with `out_ready=0` → `out_valid=1` from the cycle after the first push; `count=3`; head `out_pc=0x1c000000`.
- Fill with DEPTH=8, SKID=2, no pops:
  - `stall_full_instr` = 0 at count 5 and 1 at count 6.
  - pushes 7 and 8 are accepted.
  - a 9th push is dropped, `overflow=1`, and the head is unchanged.
- Wrap-around: stream 20 sequential instrs (`pc = 0x1c000000 + 4i`, instr `=i`) with `out_ready` toggling pseudo-randomly → ID receives all 20, in order, without loss or duplication.
- Full and pushing with `out_ready=1`: one pop happens, the push is blocked that cycle, and `count` goes 8→7.
- With `count=5`, assert `flush` together with `in_valid=1` and `out_ready=1` → next cycle `count=0`, `out_valid=0`, `stall_full_instr=0`. A push of pc `0x1c000100` on the following edge appears at the head.
- Drop `rstn` asynchronously mid-cycle with `count=6` → `out_valid`, `stall_full_instr` and `overflow` all go to 0 before the next clock edge.

Source files
------------

// File: rtl/instr_buffer.sv
// rtl/instr_buffer.sv - fetch-to-decode instruction FIFO with skid-aware stall and flush
module instr_buffer #(
    parameter int DEPTH = 8,
    parameter int SKID  = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_instr,
    output logic        stall_full_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT   = (AW+1)'(DEPTH);
    localparam logic [AW:0] STALL_CNT  = (AW+1)'(DEPTH - SKID);

    logic [63:0]   mem_q [DEPTH];
    logic [63:0]   mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          full;
    logic          push;
    logic          pop;

    // Handshake qualifiers; a full buffer refuses pushes even when popping
    always_comb begin
        full      = (count_q == FULL_CNT);
        out_valid = (count_q != '0);
        push      = in_valid & ~full;
        pop       = out_valid & out_ready;
    end

    // Next-state: flush wins over push/pop, overflow is sticky until reset
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (in_valid & full & ~flush);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {in_pc, in_instr};
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // State registers; reset clears storage so the head never reads X
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Show-ahead head read and registered-only stall/overflow outputs
    always_comb begin
        out_pc           = mem_q[rd_ptr_q][63:32];
        out_instr        = mem_q[rd_ptr_q][31:0];
        stall_full_instr = (count_q >= STALL_CNT);
        overflow         = overflow_q;
    end

endmodule

// File: tb/tb_instr_buffer.sv
// tb/tb_instr_buffer.sv - randomized self-checking bench for instr_buffer
module tb_instr_buffer;

    localparam int DEPTH = 8;
    localparam int SKID  = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        stall_full_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] mq[$];
    bit          m_ovf;
    logic [31:0] rx_pc[$];
    logic [31:0] rx_instr[$];

    instr_buffer #(.DEPTH(DEPTH), .SKID(SKID)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_pc            (in_pc),
        .in_instr         (in_instr),
        .stall_full_instr (stall_full_instr),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_pc           (out_pc),
        .out_instr        (out_instr),
        .overflow         (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(mq.size() != 0));
        check({tag, ".stall"}, 64'(stall_full_instr), 64'(mq.size() >= DEPTH - SKID));
        check({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
        check({tag, ".count"}, 64'(dut.count_q), 64'(mq.size()));
        if (mq.size() != 0) begin
            check({tag, ".head"}, {out_pc, out_instr}, mq[0]);
        end
    endtask

    // Called at a falling edge: drive inputs, advance the model, then check at the next falling edge
    task automatic cycle(input string tag, input bit f, input bit v, input logic [31:0] pc,
                         input logic [31:0] ins, input bit rdy);
        bit do_pop;
        bit do_push;
        flush     = f;
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = rdy;
        if (out_valid && rdy && !f) begin
            rx_pc.push_back(out_pc);
            rx_instr.push_back(out_instr);
        end
        if (f) begin
            mq.delete();
        end else begin
            do_pop  = (mq.size() != 0) && rdy;
            do_push = v && (mq.size() != DEPTH);
            if (v && mq.size() == DEPTH) m_ovf = 1'b1;
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back({pc, ins});
        end
        @(posedge clk);
        @(negedge clk);
        check_state(tag);
    endtask

    task automatic idle(input string tag);
        cycle(tag, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        int guard;
        int next_i;
        rstn      = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        out_ready = 1'b0;
        m_ovf     = 1'b0;

        // Reset values, including cleared storage behind the head
        @(negedge clk);
        check_state("reset");
        check("reset.out_pc", 64'(out_pc), 64'h0);
        check("reset.out_instr", 64'(out_instr), 64'h0);
        rstn = 1'b1;

        // Three pushes with ID stalled; valid from the cycle after the first push
        for (int i = 0; i < 3; i++) begin
            cycle("push3", 1'b0, 1'b1, 32'h1c000000 + 32'(4 * i), 32'(i), 1'b0);
            check("push3.valid", 64'(out_valid), 64'h1);
        end
        check("push3.head_pc", 64'(out_pc), 64'h1c000000);
        check("push3.count", 64'(dut.count_q), 64'd3);

        // Fill to full: stall off at 5, on at 6, pushes 7 and 8 accepted
        for (int i = 3; i < DEPTH; i++) begin
            cycle("fill", 1'b0, 1'b1, 32'h1c000000 + 32'(4 * i), 32'(i), 1'b0);
            if (i == 4) check("fill.stall_at5", 64'(stall_full_instr), 64'h0);
            if (i == 5) check("fill.stall_at6", 64'(stall_full_instr), 64'h1);
        end
        check("fill.count8", 64'(dut.count_q), 64'd8);
        check("fill.no_ovf", 64'(overflow), 64'h0);

        // Ninth push dropped, overflow set, head unchanged
        cycle("drop", 1'b0, 1'b1, 32'hdead0000, 32'hbad, 1'b0);
        check("drop.overflow", 64'(overflow), 64'h1);
        check("drop.head_pc", 64'(out_pc), 64'h1c000000);

        // Full with push and pop: pop only, count 8 -> 7
        cycle("fullpp", 1'b0, 1'b1, 32'hdead0004, 32'hbad, 1'b1);
        check("fullpp.count7", 64'(dut.count_q), 64'd7);
        check("fullpp.head_pc", 64'(out_pc), 64'h1c000004);

        // Drain to 5, then flush with concurrent push and pop
        cycle("drain", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        cycle("drain", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        check("drain.count5", 64'(dut.count_q), 64'd5);
        cycle("flush", 1'b1, 1'b1, 32'h1c0000f0, 32'h77, 1'b1);
        check("flush.count", 64'(dut.count_q), 64'd0);
        check("flush.valid", 64'(out_valid), 64'h0);
        check("flush.stall", 64'(stall_full_instr), 64'h0);
        cycle("postflush", 1'b0, 1'b1, 32'h1c000100, 32'h100, 1'b0);
        check("postflush.head_pc", 64'(out_pc), 64'h1c000100);

        // Drain, then stream 20 sequential instructions with random ID readiness
        while (mq.size() != 0) cycle("empty", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        rx_pc.delete();
        rx_instr.delete();
        next_i = 0;
        guard  = 0;
        while ((rx_pc.size() < 20) && (guard < 500)) begin
            bit v;
            v = (next_i < 20) && !stall_full_instr && ($urandom_range(0, 3) != 0);
            cycle("stream", 1'b0, v, 32'h1c000000 + 32'(4 * next_i), 32'(next_i),
                  1'($urandom_range(0, 1)));
            if (v) next_i++;
            guard++;
        end
        check("stream.received", 64'(rx_pc.size()), 64'd20);
        for (int i = 0; i < rx_pc.size() && i < 20; i++) begin
            check("stream.pc", 64'(rx_pc[i]), 64'(32'h1c000000 + 32'(4 * i)));
            check("stream.instr", 64'(rx_instr[i]), 64'(i));
        end

        // Random traffic with occasional flushes
        for (int n = 0; n < 400; n++) begin
            bit f;
            f = ($urandom_range(0, 19) == 0);
            cycle("rand", f, f ? 1'b0 : 1'($urandom_range(0, 2) != 0), $urandom, $urandom,
                  1'($urandom_range(0, 1)));
        end

        // Async reset mid-cycle with six entries and overflow set
        cycle("prerst", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cycle("prerst", 1'b0, 1'b1, 32'h2000 + 32'(4 * i), 32'(i), 1'b0);
        end
        check("prerst.count6", 64'(dut.count_q), 64'd6);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        mq.delete();
        m_ovf = 1'b0;
        check("arst.out_valid", 64'(out_valid), 64'h0);
        check("arst.stall", 64'(stall_full_instr), 64'h0);
        check("arst.overflow", 64'(overflow), 64'h0);
        check("arst.out_pc", 64'(out_pc), 64'h0);
        @(negedge clk);
        rstn = 1'b1;
        cycle("afterrst", 1'b0, 1'b1, 32'h1c000200, 32'h5, 1'b0);
        check("afterrst.head_pc", 64'(out_pc), 64'h1c000200);
        idle("afterrst.idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
